// File: rtl/perf_pkg.sv
// Shared definitions for the performance-counter bank: register field
// positions, the per-counter control layout and the address map.
package perf_pkg;

  // Per-counter control register fields
  localparam int EVT_SEL_LSB = 0;
  localparam int EVT_SEL_MSB = 7;
  localparam int EN_BIT      = 8;
  localparam int SAT_BIT     = 9;
  localparam int IE_BIT      = 10;

  // Global control register fields
  localparam int GEN_BIT  = 0;
  localparam int FRZ_BIT  = 1;
  localparam int SNAP_BIT = 2;

  // Control register image, MSB first so it lines up with the bit positions above
  typedef struct packed {
    logic       ovf_ie;
    logic       sat;
    logic       en;
    logic [7:0] evt_sel;
  } ctrl_t;

  // Address map, all word addresses, as functions of the counter count
  function automatic int cnt_addr(input int num_cnt, input int idx);
    return idx + 0 * num_cnt;
  endfunction

  function automatic int ctrl_addr(input int num_cnt, input int idx);
    return num_cnt + idx;
  endfunction

  function automatic int glb_addr(input int num_cnt);
    return 2 * num_cnt;
  endfunction

  function automatic int ovf_addr(input int num_cnt);
    return 2 * num_cnt + 1;
  endfunction

  // 2*num_cnt+2 is reserved and reads as zero; shadows start right after it
  function automatic int shadow_addr(input int num_cnt, input int idx);
    return 2 * num_cnt + 3 + idx;
  endfunction

endpackage

// File: rtl/perf_counter_bank_if.sv
// Register port of the performance-counter bank.
//
// Handshake: reg_we/reg_re are single-cycle strobes qualified by reg_addr.
// A write takes effect at the clock edge that samples reg_we. A read issued
// in cycle t returns rd_valid=1 with rd_data in cycle t+1; there is no
// backpressure, so a read may be issued every cycle. Outside a read response
// rd_valid is 0 and rd_data keeps its last value.
interface perf_counter_bank_if #(
  parameter int ADDR_W = 5
);
  logic              reg_we;
  logic              reg_re;
  logic [ADDR_W-1:0] reg_addr;
  logic [31:0]       reg_wdata;
  logic              rd_valid;
  logic [31:0]       rd_data;

  modport master (
    output reg_we, reg_re, reg_addr, reg_wdata,
    input  rd_valid, rd_data
  );

  modport slave (
    input  reg_we, reg_re, reg_addr, reg_wdata,
    output rd_valid, rd_data
  );
endinterface

// File: rtl/perf_counter_slice.sv
// One programmable counter: live count, shadow copy, control register,
// and the increment / overflow behaviour (wrap or saturate).
module perf_counter_slice
  import perf_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             evt_hit_i,    // selected event fired and global gating allows counting
  input  logic             cnt_we_i,     // preset the count
  input  logic [CNT_W-1:0] cnt_wdata_i,
  input  logic             ctrl_we_i,    // write the control register
  input  ctrl_t            ctrl_wdata_i,
  input  logic             snap_i,       // copy count into shadow
  input  logic             ovf_clr_i,    // write-1-to-clear of the overflow flag
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] shadow_o,
  output ctrl_t            ctrl_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             ovf_q, ovf_d;
  logic             inc;
  logic             at_max;

  // Next-state: a preset beats an increment; a new overflow beats a clear
  always_comb begin
    inc      = evt_hit_i & ctrl_q.en;
    at_max   = &count_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    shadow_d = shadow_q;
    ctrl_d   = ctrl_q;

    if (cnt_we_i) begin
      count_d = cnt_wdata_i;
    end else if (inc) begin
      if (at_max) begin
        count_d = ctrl_q.sat ? count_q : '0;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end

    if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end
    if (inc && at_max && !cnt_we_i) begin
      ovf_d = 1'b1;
    end

    // Shadow captures the value present before this edge's increment
    if (snap_i) begin
      shadow_d = count_q;
    end

    if (ctrl_we_i) begin
      ctrl_d = ctrl_wdata_i;
    end
  end

  // Counter state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      shadow_q <= '0;
      ctrl_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      shadow_q <= shadow_d;
      ctrl_q   <= ctrl_d;
      ovf_q    <= ovf_d;
    end
  end

  assign count_o  = count_q;
  assign shadow_o = shadow_q;
  assign ctrl_o   = ctrl_q;
  assign ovf_o    = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CNT programmable event counters with a one-cycle-latency
// register port, global enable/freeze, snapshot and overflow interrupt.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_CNT = 8,
  parameter int NUM_EVT = 16,
  parameter int CNT_W   = 32,
  parameter int ADDR_W  = $clog2(2 * NUM_CNT + 3)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               halt,
  output logic               irq,
  perf_counter_bank_if.slave bus
);

  localparam int GLB_A = glb_addr(NUM_CNT);
  localparam int OVF_A = ovf_addr(NUM_CNT);

  int                 addr_idx;
  logic               gen_q, gen_d;
  logic               frz_q, frz_d;
  logic               rd_valid_q, rd_valid_d;
  logic [31:0]        rd_data_q, rd_data_d;
  logic [31:0]        rd_mux;
  logic               glb_we;
  logic               snap;
  logic               cnt_gate;
  ctrl_t              wr_ctrl;
  logic [NUM_CNT-1:0] cnt_we;
  logic [NUM_CNT-1:0] ctrl_we;
  logic [NUM_CNT-1:0] ovf_clr;
  logic [NUM_CNT-1:0] evt_hit;
  logic [NUM_CNT-1:0] ovf_vec;
  logic [NUM_CNT-1:0] ie_vec;
  logic [CNT_W-1:0]   cnt_val    [NUM_CNT];
  logic [CNT_W-1:0]   shadow_val [NUM_CNT];
  ctrl_t              ctrl_val   [NUM_CNT];

  assign addr_idx = int'(bus.reg_addr);
  assign cnt_gate = gen_q & ~(frz_q & halt);

  // Write-data view of a control register
  always_comb begin
    wr_ctrl         = '0;
    wr_ctrl.evt_sel = bus.reg_wdata[EVT_SEL_MSB:EVT_SEL_LSB];
    wr_ctrl.en      = bus.reg_wdata[EN_BIT];
    wr_ctrl.sat     = bus.reg_wdata[SAT_BIT];
    wr_ctrl.ovf_ie  = bus.reg_wdata[IE_BIT];
  end

  // Address decode into per-slice and global write strobes
  always_comb begin
    glb_we  = bus.reg_we && (addr_idx == GLB_A);
    snap    = glb_we && bus.reg_wdata[SNAP_BIT];
    cnt_we  = '0;
    ctrl_we = '0;
    ovf_clr = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_we[i]  = bus.reg_we && (addr_idx == cnt_addr(NUM_CNT, i));
      ctrl_we[i] = bus.reg_we && (addr_idx == ctrl_addr(NUM_CNT, i));
      ovf_clr[i] = bus.reg_we && (addr_idx == OVF_A) && bus.reg_wdata[i];
    end
  end

  // Event selection; selectors beyond NUM_EVT match nothing and never count
  always_comb begin
    evt_hit = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      for (int k = 0; k < NUM_EVT; k++) begin
        if ((ctrl_val[i].evt_sel == 8'(k)) && evt[k]) begin
          evt_hit[i] = cnt_gate;
        end
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_CNT; g++) begin : g_slice
      perf_counter_slice #(
        .CNT_W (CNT_W)
      ) u_slice (
        .clk          (clk),
        .reset        (reset),
        .evt_hit_i    (evt_hit[g]),
        .cnt_we_i     (cnt_we[g]),
        .cnt_wdata_i  (bus.reg_wdata[CNT_W-1:0]),
        .ctrl_we_i    (ctrl_we[g]),
        .ctrl_wdata_i (wr_ctrl),
        .snap_i       (snap),
        .ovf_clr_i    (ovf_clr[g]),
        .count_o      (cnt_val[g]),
        .shadow_o     (shadow_val[g]),
        .ctrl_o       (ctrl_val[g]),
        .ovf_o        (ovf_vec[g])
      );
      assign ie_vec[g] = ctrl_val[g].ovf_ie;
    end
  endgenerate

  // Read mux over the current register values, so a same-cycle write is not seen
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (addr_idx == cnt_addr(NUM_CNT, i)) begin
        rd_mux = 32'(cnt_val[i]);
      end
      if (addr_idx == ctrl_addr(NUM_CNT, i)) begin
        rd_mux = 32'(ctrl_val[i]);
      end
      // Only matches when the shadow address fits in ADDR_W
      if (addr_idx == shadow_addr(NUM_CNT, i)) begin
        rd_mux = 32'(shadow_val[i]);
      end
    end
    if (addr_idx == GLB_A) begin
      rd_mux = '0;
      rd_mux[GEN_BIT] = gen_q;
      rd_mux[FRZ_BIT] = frz_q;
    end
    if (addr_idx == OVF_A) begin
      rd_mux = 32'(ovf_vec);
    end
  end

  // Next-state for global control and the read response
  always_comb begin
    gen_d      = gen_q;
    frz_d      = frz_q;
    rd_valid_d = bus.reg_re;
    rd_data_d  = rd_data_q;
    if (glb_we) begin
      gen_d = bus.reg_wdata[GEN_BIT];
      frz_d = bus.reg_wdata[FRZ_BIT];
    end
    if (bus.reg_re) begin
      rd_data_d = rd_mux;
    end
  end

  // Global control and read response registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gen_q      <= 1'b1;
      frz_q      <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      gen_q      <= gen_d;
      frz_q      <= frz_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign irq          = |(ovf_vec & ie_vec);

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench: two banks share all stimulus, one 32-bit wide (A) and one
// 4-bit wide (B) so wrap/saturate at all-ones is reachable in a few events.
// Map for NUM_CNT=8: counters 0..7, controls 8..15, global 16, ovf 17,
// reserved 18, shadows 19..26, 27..31 unmapped.
module tb_perf_counter_bank;

  localparam int NUM_CNT = 8;
  localparam int NUM_EVT = 16;
  localparam int ADDR_W  = 5;

  logic               clk;
  logic               reset;
  logic [NUM_EVT-1:0] evt;
  logic               halt;
  logic               reg_we;
  logic               reg_re;
  logic [ADDR_W-1:0]  reg_addr;
  logic [31:0]        reg_wdata;
  logic               irq_a;
  logic               irq_b;

  int checks;
  int errors;

  perf_counter_bank_if #(.ADDR_W(ADDR_W)) bus_a ();
  perf_counter_bank_if #(.ADDR_W(ADDR_W)) bus_b ();

  assign bus_a.reg_we    = reg_we;
  assign bus_a.reg_re    = reg_re;
  assign bus_a.reg_addr  = reg_addr;
  assign bus_a.reg_wdata = reg_wdata;
  assign bus_b.reg_we    = reg_we;
  assign bus_b.reg_re    = reg_re;
  assign bus_b.reg_addr  = reg_addr;
  assign bus_b.reg_wdata = reg_wdata;

  perf_counter_bank #(
    .NUM_CNT (NUM_CNT),
    .NUM_EVT (NUM_EVT),
    .CNT_W   (32),
    .ADDR_W  (ADDR_W)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .evt   (evt),
    .halt  (halt),
    .irq   (irq_a),
    .bus   (bus_a)
  );

  perf_counter_bank #(
    .NUM_CNT (NUM_CNT),
    .NUM_EVT (NUM_EVT),
    .CNT_W   (4),
    .ADDR_W  (ADDR_W)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .evt   (evt),
    .halt  (halt),
    .irq   (irq_b),
    .bus   (bus_b)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Drivers: all start and end on a falling edge
  task automatic wr(input logic [ADDR_W-1:0] addr, input logic [31:0] data);
    reg_we    = 1'b1;
    reg_addr  = addr;
    reg_wdata = data;
    @(negedge clk);
    reg_we    = 1'b0;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] addr, output logic [31:0] da, output logic [31:0] db);
    reg_re   = 1'b1;
    reg_addr = addr;
    @(posedge clk);
    #1;
    check("rd_valid", 32'(bus_a.rd_valid), 32'd1);
    da = bus_a.rd_data;
    db = bus_b.rd_data;
    @(negedge clk);
    reg_re = 1'b0;
  endtask

  task automatic pulse(input logic [NUM_EVT-1:0] mask, input int n);
    evt = mask;
    repeat (n) @(negedge clk);
    evt = '0;
  endtask

  logic [31:0] da, db;

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    evt       = '0;
    halt      = 1'b0;
    reg_we    = 1'b0;
    reg_re    = 1'b0;
    reg_addr  = '0;
    reg_wdata = '0;
    #1;
    check("rst_rd_valid", 32'(bus_a.rd_valid), 32'd0);
    check("rst_rd_data", bus_a.rd_data, 32'd0);
    check("rst_irq", 32'(irq_a), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset values
    rd(5'd0, da, db);  check("rst_cnt0", da, 32'd0);
    rd(5'd16, da, db); check("rst_glb", da, 32'd3);
    rd(5'd17, da, db); check("rst_ovf", da, 32'd0);
    rd(5'd8, da, db);  check("rst_ctrl0", da, 32'd0);

    // Counter 0 on event 3, event 2 active throughout as a distractor
    wr(5'd8, 32'h103);
    pulse(16'h000C, 5);
    pulse(16'h0004, 3);
    rd(5'd0, da, db);  check("cnt0_evt3", da, 32'd5);
    rd(5'd8, da, db);  check("ctrl0_rb", da, 32'h103);
    // rd_data holds and rd_valid drops when no read is issued
    @(posedge clk); #1;
    check("idle_rd_valid", 32'(bus_a.rd_valid), 32'd0);
    check("idle_rd_hold", bus_a.rd_data, 32'h103);
    @(negedge clk);

    // Wrap on the 4-bit bank: 14 -> 15 -> 0 (ovf) -> 1
    wr(5'd9, 32'h105);
    wr(5'd1, 32'd14);
    pulse(16'h0020, 3);
    rd(5'd1, da, db);  check("wrap_b_cnt1", db, 32'd1);
    check("wide_a_cnt1", da, 32'd17);
    rd(5'd17, da, db); check("wrap_b_ovf", db, 32'h2);
    check("wrap_a_ovf", da, 32'h0);
    check("wrap_irq_no_ie", 32'(irq_b), 32'd0);
    wr(5'd9, 32'h505);
    check("wrap_irq_ie", 32'(irq_b), 32'd1);
    check("wrap_irq_a", 32'(irq_a), 32'd0);
    wr(5'd17, 32'h2);
    check("w1c_irq", 32'(irq_b), 32'd0);
    rd(5'd17, da, db); check("w1c_ovf", db, 32'h0);

    // Saturate on the 4-bit bank: 14 -> 15, then held at 15
    wr(5'd10, 32'h306);
    wr(5'd2, 32'd14);
    pulse(16'h0040, 5);
    rd(5'd2, da, db);  check("sat_b_cnt2", db, 32'd15);
    check("sat_a_cnt2", da, 32'd19);
    rd(5'd17, da, db); check("sat_b_ovf", db, 32'h4);

    // Freeze while halted, then resume with frz=0, then gen=0 stops counting
    halt = 1'b1;
    pulse(16'h0008, 4);
    rd(5'd0, da, db);  check("frz_hold", da, 32'd5);
    wr(5'd16, 32'h1);
    pulse(16'h0008, 2);
    rd(5'd0, da, db);  check("frz_off", da, 32'd7);
    rd(5'd16, da, db); check("glb_frz0", da, 32'd1);
    wr(5'd16, 32'h0);
    pulse(16'h0008, 2);
    rd(5'd0, da, db);  check("gen_off", da, 32'd7);
    halt = 1'b0;
    wr(5'd16, 32'h3);

    // A preset in the same cycle as an event wins
    evt = 16'h0008;
    wr(5'd0, 32'd100);
    evt = '0;
    rd(5'd0, da, db);  check("wr_wins", da, 32'd100);
    check("wr_trunc_b", db, 32'd4);

    // Snap during an increment captures the pre-increment value
    evt = 16'h0008;
    wr(5'd16, 32'h5);
    evt = '0;
    rd(5'd19, da, db); check("snap_shadow_a", da, 32'd100);
    check("snap_shadow_b", db, 32'd4);
    rd(5'd0, da, db);  check("snap_cnt_a", da, 32'd101);
    check("snap_cnt_b", db, 32'd5);
    rd(5'd16, da, db); check("snap_reads0", da, 32'd1);

    // Read and write of the same address in one cycle returns the old value
    reg_re    = 1'b1;
    reg_we    = 1'b1;
    reg_addr  = 5'd0;
    reg_wdata = 32'd200;
    @(posedge clk); #1;
    check("rw_old", bus_a.rd_data, 32'd101);
    @(negedge clk);
    reg_re = 1'b0;
    reg_we = 1'b0;
    rd(5'd0, da, db);  check("rw_new", da, 32'd200);

    // Unmapped and reserved addresses read zero
    rd(5'd18, da, db); check("unmapped18", da, 32'd0);
    rd(5'd31, da, db); check("unmapped31", da, 32'd0);

    // Asynchronous reset in the middle of counting with a read in flight
    wr(5'd10, 32'h706);
    check("pre_rst_irq", 32'(irq_b), 32'd1);
    evt      = 16'h0008;
    reg_re   = 1'b1;
    reg_addr = 5'd0;
    @(posedge clk); #1;
    check("pre_rst_valid", 32'(bus_a.rd_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rd_valid", 32'(bus_a.rd_valid), 32'd0);
    check("async_rd_data", bus_a.rd_data, 32'd0);
    check("async_irq", 32'(irq_b), 32'd0);
    @(negedge clk);
    reg_re = 1'b0;
    evt    = '0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_valid", 32'(bus_a.rd_valid), 32'd0);
    @(negedge clk);
    rd(5'd0, da, db);  check("post_rst_cnt0", da, 32'd0);
    rd(5'd16, da, db); check("post_rst_glb", da, 32'd3);
    rd(5'd8, da, db);  check("post_rst_ctrl0", da, 32'd0);
    rd(5'd19, da, db); check("post_rst_shadow0", da, 32'd0);
    rd(5'd17, da, db); check("post_rst_ovf_b", db, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
